shift_sum_accum: RTL and testbench
==================================

Name: shift_sum_accum

Overview:
- Parametrised streaming weighted shift-sum unit with burst accumulator.
- Each accepted beat carries NCH operand slices; the block computes their shift-weighted sum and accumulates it over a burst.
- A burst is BURST beats, or fewer if ended by in_last. At burst end it presents the total with valid/ready handshakes on both sides.
- Sits in the arithmetic test datapath as the generalised, pipelined successor of the fixed three-operand sum/accumulate block.

Parameters:
- W, 8, accumulator and result width.
- IW, 4, width of each operand slice.
- NCH, 3, number of operand channels per beat (>=1).
- SHIFT_STEP, 2, weight shift between adjacent channels; channel i is shifted left by i*SHIFT_STEP.
- BURST, 3, maximum beats per burst (>=1).

Ports:
- clk  input  1  clock, all logic on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  input beat valid.
- in_ready  output  1  block can accept a beat.
- in_data  input  NCH*IW  operand slices; channel i is in_data[i*IW +: IW], channel 0 in the LSBs.
- in_last  input  1  beat is the last of the burst (early termination).
- flush  input  1  abort the partial burst.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts the result.
- out_sum  output  W  accumulated burst result.
- out_beats  output  clog2(BURST+1)  number of beats in the result.
- out_ovf  output  1  overflow occurred in this burst.

Behaviour:
- Reset: the synchronous active-high reset is decided and fixed. While rst=1 at a clk edge:
  - state <= ACC, cnt <= 0, acc <= 0;
  - out_valid=0, out_sum=0, out_beats=0, out_ovf=0;
  - in_ready=0 during the reset cycle.
  - Reset mid-burst or while holding a result discards everything.
- Term computation (combinational on in_data):
  - term_full = sum over i of zero-extended slice_i << (i*SHIFT_STEP).
  - Computed at width IW+(NCH-1)*SHIFT_STEP+clog2(NCH).
  - term = term_full truncated to W bits. A term overflow is flagged if term_full >= 2^W.
- States:
  - ACC: in_ready=1, out_valid=0.
  - HOLD: in_ready=0, out_valid=1.
- Accept condition: a beat is accepted when state=ACC and in_valid=1 and flush=0.
- Accumulation on accept:
  - if cnt==0: acc <= term, ovf <= term overflow;
  - else: acc <= (acc+term) mod 2^W, ovf <= ovf | term overflow | carry out of the add.
  - cnt increments on each accepted beat.
- End of burst: the accepted beat has in_last=1 or cnt==BURST-1. On that edge:
  - state <= HOLD;
  - out_sum, out_ovf and out_beats are loaded with the final values (out_beats = cnt+1);
  - cnt <= 0.
- Latency: out_valid rises the cycle after the final beat is accepted.
- HOLD: outputs stay stable until out_valid && out_ready. On that edge, state <= ACC. There is no same-cycle re-accept; in_ready returns 1 in the following cycle.
- Flush:
  - in ACC, flush=1 sets cnt <= 0, acc <= 0, ovf <= 0; any in_valid beat that cycle is dropped.
  - in HOLD, flush is ignored; the result is always delivered.
- Bursts: BURST=1 makes every beat a burst. in_last on the first beat gives out_beats=1.
- out_sum, out_beats and out_ovf hold their last values while out_valid=0.

Optional Feature:
- Macro SHIFT_SUM_SAT_EN.
- Defined:
  - term clamps to 2^W-1 when term_full >= 2^W;
  - each add clamps at 2^W-1 instead of wrapping;
  - out_ovf still reports that clamping occurred.
- Undefined: modulo-2^W wrap as described above.
- Handshake, timing and out_ovf semantics are identical in both cases.

Test Plan:
1. Defaults, 3 beats of slices (s0,s1,s2)=(1,2,3), in_last=0. Each term = 1+8+48 = 57, so out_sum=171, out_beats=3, out_ovf=0. out_valid is asserted 1 cycle after the 3rd accept.
2. Beats (15,15,15) x3. Wrap build: term=315 mod 256=59, so out_sum=177, out_ovf=1. SHIFT_SUM_SAT_EN build: out_sum=255, out_ovf=1.
3. Beat (1,2,3) then (4,0,0) with in_last=1 → out_sum=61, out_beats=2. The next burst starts fresh at cnt=0.
4. Backpressure: hold out_ready=0 for 5 cycles after a result → out_valid and out_sum stay stable and in_ready=0 throughout. Then out_ready=1 for one cycle → in_ready=1 on the next cycle.
5. Two beats of 57, then flush=1 with in_valid=1, then 3 beats of (0,1,0) → out_sum=12, out_beats=3; the flushed partial sum is absent.
6. Assert rst in HOLD with out_valid=1 → next cycle out_valid=0, out_sum=0, out_ovf=0, in_ready=1. The next burst of one beat (2,0,0) with in_last=1 → out_sum=2.

Source files
------------

// File: rtl/shift_sum_accum.sv
// shift_sum_accum: streaming shift-weighted sum of NCH operand slices per beat,
// accumulated over a burst of up to BURST beats (or fewer if ended by in_last).
// At the end of a burst the total is held behind a valid/ready handshake.
// Optional build macro: SHIFT_SUM_SAT_EN. When defined, the term and the
// running sum saturate at 2^W-1 instead of wrapping. out_ovf reports the
// clamping or wrapping event in both builds.
module shift_sum_accum #(
  parameter int W          = 8,
  parameter int IW         = 4,
  parameter int NCH        = 3,
  parameter int SHIFT_STEP = 2,
  parameter int BURST      = 3
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [NCH*IW-1:0]            in_data,
  input  logic                         in_last,
  input  logic                         flush,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [W-1:0]                 out_sum,
  output logic [$clog2(BURST+1)-1:0]   out_beats,
  output logic                         out_ovf
);

  localparam int CW = $clog2(BURST + 1);
  // Natural width of the weighted sum.
  localparam int TW = IW + (NCH - 1) * SHIFT_STEP + $clog2(NCH);
  // Widened to at least W+1 so the overflow test always has a bit above W.
  localparam int EW = (TW > W) ? TW : W + 1;

  typedef enum logic {
    ACC  = 1'b0,
    HOLD = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [W-1:0]    acc_q, acc_d;
  logic            ovf_q, ovf_d;
  logic [W-1:0]    out_sum_q, out_sum_d;
  logic [CW-1:0]   out_beats_q, out_beats_d;
  logic            out_ovf_q, out_ovf_d;

  logic [EW-1:0]   shifted [NCH];
  logic [EW-1:0]   term_full;
  logic            term_ovf;
  logic [W-1:0]    term;
  logic [W:0]      add_ext;
  logic            add_carry;
  logic [W-1:0]    add_res;

  // Each channel zero-extended and placed at its weight.
  for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
    assign shifted[gi] = EW'(in_data[gi*IW +: IW]) << (gi * SHIFT_STEP);
  end

  // Sum the weighted channels at full width.
  always_comb begin
    term_full = '0;
    for (int i = 0; i < NCH; i++) begin
      term_full = term_full + shifted[i];
    end
  end

  assign term_ovf  = |term_full[EW-1:W];
  assign add_ext   = {1'b0, acc_q} + {1'b0, term};
  assign add_carry = add_ext[W];

`ifdef SHIFT_SUM_SAT_EN
  assign term    = term_ovf  ? {W{1'b1}} : term_full[W-1:0];
  assign add_res = add_carry ? {W{1'b1}} : add_ext[W-1:0];
`else
  assign term    = term_full[W-1:0];
  assign add_res = add_ext[W-1:0];
`endif

  // Next-state, accumulation and handshake outputs.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    ovf_d       = ovf_q;
    out_sum_d   = out_sum_q;
    out_beats_d = out_beats_q;
    out_ovf_d   = out_ovf_q;
    in_ready    = 1'b0;
    out_valid   = 1'b0;

    case (state_q)
      ACC: begin
        in_ready = 1'b1;
        if (flush) begin
          // Abort the partial burst; a beat offered this cycle is dropped.
          cnt_d = '0;
          acc_d = '0;
          ovf_d = 1'b0;
        end else if (in_valid) begin
          if (cnt_q == '0) begin
            acc_d = term;
            ovf_d = term_ovf;
          end else begin
            acc_d = add_res;
            ovf_d = ovf_q | term_ovf | add_carry;
          end
          if (in_last || (cnt_q == CW'(BURST - 1))) begin
            state_d     = HOLD;
            out_sum_d   = acc_d;
            out_ovf_d   = ovf_d;
            out_beats_d = cnt_q + CW'(1);
            cnt_d       = '0;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        // Result is always delivered; flush has no effect here.
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = ACC;
        end
      end
      default: begin
        state_d = ACC;
      end
    endcase

    // Nothing is offered or accepted while reset is applied.
    if (rst) begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
    end
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACC;
      cnt_q       <= '0;
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      out_sum_q   <= '0;
      out_beats_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      ovf_q       <= ovf_d;
      out_sum_q   <= out_sum_d;
      out_beats_q <= out_beats_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign out_sum   = out_sum_q;
  assign out_beats = out_beats_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: tb/tb_shift_sum_accum.sv
// Testbench for shift_sum_accum: directed scenarios followed by random traffic.
// Expected burst results are queued by the driver and checked by an
// independent output monitor. Honours SHIFT_SUM_SAT_EN like the design.
module tb_shift_sum_accum;

  localparam int W          = 8;
  localparam int IW         = 4;
  localparam int NCH        = 3;
  localparam int SHIFT_STEP = 2;
  localparam int BURST      = 3;
  localparam int CW         = $clog2(BURST + 1);
  localparam int MAXV       = (1 << W) - 1;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [NCH*IW-1:0] in_data = '0;
  logic              in_last = 1'b0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [W-1:0]      out_sum;
  logic [CW-1:0]     out_beats;
  logic              out_ovf;

  shift_sum_accum #(
    .W(W), .IW(IW), .NCH(NCH), .SHIFT_STEP(SHIFT_STEP), .BURST(BURST)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_last(in_last), .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_beats(out_beats), .out_ovf(out_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int sum;
    int beats;
    int ovf;
  } exp_t;

  exp_t exp_q[$];
  int   terms[$];      // full-precision terms of the burst in progress
  bit   hold_m = 1'b0; // model: a result is waiting to be taken
  int   total = 0;
  int   bad = 0;
  int   last_sum = -1, last_beats = -1, last_ovf = -1;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic logic [NCH*IW-1:0] pk(input int s0, input int s1, input int s2);
    logic [NCH*IW-1:0] d;
    d = {IW'(s2), IW'(s1), IW'(s0)};
    return d;
  endfunction

  // Weighted value of a beat in ordinary integer arithmetic.
  function automatic int ref_full(input logic [NCH*IW-1:0] d);
    int s = 0;
    for (int i = 0; i < NCH; i++) begin
      s += int'(d[i*IW +: IW]) * (1 << (i * SHIFT_STEP));
    end
    return s;
  endfunction

  // Expected result of a completed burst from its list of terms.
  function automatic exp_t burst_result();
    exp_t e;
    int tot = 0;
    int any = 0;
    foreach (terms[k]) begin
      if (terms[k] > MAXV) any = 1;
`ifdef SHIFT_SUM_SAT_EN
      tot += (terms[k] > MAXV) ? MAXV : terms[k];
`else
      tot += terms[k] % (MAXV + 1);
`endif
    end
`ifdef SHIFT_SUM_SAT_EN
    e.sum = (tot > MAXV) ? MAXV : tot;
`else
    e.sum = tot % (MAXV + 1);
`endif
    e.ovf   = (any != 0 || tot > MAXV) ? 1 : 0;
    e.beats = terms.size();
    return e;
  endfunction

  // One clock cycle of stimulus with model update.
  task automatic cycle(input bit v, input logic [NCH*IW-1:0] d, input bit last,
                       input bit fl, input bit ordy);
    @(posedge clk); #1;
    in_valid = v; in_data = d; in_last = last; flush = fl; out_ready = ordy;
    @(negedge clk);
    chk("in_ready", int'(in_ready), int'(!hold_m));
    chk("out_valid", int'(out_valid), int'(hold_m));
    if (hold_m) begin
      if (ordy) hold_m = 1'b0;
    end else if (fl) begin
      terms.delete();
    end else if (v) begin
      terms.push_back(ref_full(d));
      if (last || terms.size() == BURST) begin
        exp_q.push_back(burst_result());
        terms.delete();
        hold_m = 1'b1;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; in_valid = 1'b0; flush = 1'b0; in_last = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", int'(in_ready), 0);
    @(posedge clk); #1;
    rst = 1'b0; hold_m = 1'b0; terms.delete(); exp_q.delete();
    @(negedge clk);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_sum", int'(out_sum), 0);
    chk("rst_out_beats", int'(out_beats), 0);
    chk("rst_out_ovf", int'(out_ovf), 0);
    chk("rst_in_ready_after", int'(in_ready), 1);
  endtask

  // Output monitor: a held result must match the queue head every cycle.
  always @(negedge clk) begin
    if (!rst && out_valid) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_result: got sum=%0d with no result expected", out_sum);
      end else begin
        chk("out_sum", int'(out_sum), exp_q[0].sum);
        chk("out_beats", int'(out_beats), exp_q[0].beats);
        chk("out_ovf", int'(out_ovf), exp_q[0].ovf);
        $display("result sum=%0d beats=%0d ovf=%0d ready=%0d", out_sum, out_beats, out_ovf, out_ready);
        if (out_ready) begin
          void'(exp_q.pop_front());
          last_sum = int'(out_sum);
          last_beats = int'(out_beats);
          last_ovf = int'(out_ovf);
        end
      end
    end
  end

  initial begin
    do_reset();

    // 1: three beats of (1,2,3) -> 171
    repeat (3) cycle(1, pk(1, 2, 3), 0, 0, 0);
    cycle(0, '0, 0, 0, 1);
    cycle(0, '0, 0, 0, 0);
    chk("t1_sum", last_sum, 171);
    chk("t1_beats", last_beats, 3);
    chk("t1_ovf", last_ovf, 0);

    // 2: three beats of (15,15,15)
    repeat (3) cycle(1, pk(15, 15, 15), 0, 0, 1);
    cycle(0, '0, 0, 0, 1);
    cycle(0, '0, 0, 0, 0);
`ifdef SHIFT_SUM_SAT_EN
    chk("t2_sum", last_sum, 255);
`else
    chk("t2_sum", last_sum, 177);
`endif
    chk("t2_ovf", last_ovf, 1);

    // 3: early termination with in_last, then a fresh burst
    cycle(1, pk(1, 2, 3), 0, 0, 0);
    cycle(1, pk(4, 0, 0), 1, 0, 0);
    cycle(0, '0, 0, 0, 1);
    cycle(0, '0, 0, 0, 0);
    chk("t3_sum", last_sum, 61);
    chk("t3_beats", last_beats, 2);
    cycle(1, pk(1, 0, 0), 1, 0, 0);
    cycle(0, '0, 0, 0, 1);
    cycle(0, '0, 0, 0, 0);
    chk("t3_fresh_sum", last_sum, 1);
    chk("t3_fresh_beats", last_beats, 1);

    // 4: backpressure for 5 cycles, beats offered meanwhile are ignored
    repeat (3) cycle(1, pk(1, 2, 3), 0, 0, 0);
    repeat (5) cycle(1, pk(7, 7, 7), 0, 0, 0);
    cycle(0, '0, 0, 0, 1);
    cycle(0, '0, 0, 0, 0);
    chk("t4_sum", last_sum, 171);

    // 5: flush discards a partial burst and the beat offered with it
    repeat (2) cycle(1, pk(1, 2, 3), 0, 0, 0);
    cycle(1, pk(1, 2, 3), 0, 1, 0);
    repeat (3) cycle(1, pk(0, 1, 0), 0, 0, 0);
    cycle(0, '0, 0, 0, 1);
    cycle(0, '0, 0, 0, 0);
    chk("t5_sum", last_sum, 12);
    chk("t5_beats", last_beats, 3);

    // 6: reset while holding a result
    cycle(1, pk(5, 5, 0), 1, 0, 0);
    cycle(0, '0, 0, 0, 0);
    do_reset();
    cycle(1, pk(2, 0, 0), 1, 0, 0);
    cycle(0, '0, 0, 0, 1);
    cycle(0, '0, 0, 0, 0);
    chk("t6_sum", last_sum, 2);
    chk("t6_beats", last_beats, 1);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      cycle(($urandom % 4) != 0, NCH*IW'($urandom), ($urandom % 4) == 0,
            ($urandom % 10) == 0, ($urandom % 3) != 0);
    end
    repeat (4) cycle(0, '0, 0, 0, 1);
    chk("queue_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
